// File: rtl/craft_pkg.sv
// Shared definitions for the CRAFT tweakable block cipher core.
// Holds the FSM state type, the nibble-level lookup tables (S-box,
// PermuteNibbles and its inverse, tweak permutation Q, round constants)
// and the combinational layer helpers used by the round unit and the top.
// Nibble i of a 64-bit word is bits [63-4i -: 4] (nibble 0 is the MSB).
package craft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } craft_state_t;

    localparam int MAX_ROUNDS = 32;

    localparam logic [3:0] SBOX [16] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    // Destination nibble for source nibble i.
    localparam int PN_IDX [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    // The CRAFT nibble permutation is an involution, so its inverse has the same entries.
    localparam int PN_INV_IDX [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};

    // Output nibble i of Q(T) takes tweak nibble Q_IDX[i].
    localparam int Q_IDX [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    // {a[3:0], 1'b0, b[2:0]}: 4-bit LFSR value for nibble 4, 3-bit LFSR value for nibble 5.
    localparam logic [7:0] RC_TABLE [MAX_ROUNDS] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
        8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
        8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
    };

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = SBOX[x[4*i +: 4]];
        end
        return y;
    endfunction

    function automatic logic [63:0] pn_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*PN_IDX[i] -: 4] = x[63-4*i -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] pn_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*PN_INV_IDX[i] -: 4] = x[63-4*i -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] y;
        y = 64'h0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*i -: 4] = t[63-4*Q_IDX[i] -: 4];
        end
        return y;
    endfunction

    // Column-wise MixColumn on the 4x4 nibble matrix; rows are 16-bit slices,
    // so the per-column XORs collapse into row XORs. The matrix is involutory.
    function automatic logic [63:0] mc_layer(input logic [63:0] x);
        return {x[63:48] ^ x[31:16] ^ x[15:0], x[47:32] ^ x[15:0], x[31:16], x[15:0]};
    endfunction

    // Places a round constant on nibbles 4 and 5.
    function automatic logic [63:0] rc_mask(input logic [7:0] rc);
        return {16'h0000, rc, 40'h00_0000_0000};
    endfunction

endpackage

// File: rtl/craft_round_unit.sv
// One combinational CRAFT round, forward or inverse.
// Ports: blk (state in), tk (round tweakey), rc (packed round constant),
//        decrypt (1 = inverse round), last (round index ROUNDS-1: no
//        PermuteNibbles / S-box), result (state out).
module craft_round_unit
    import craft_pkg::*;
(
    input  logic [63:0] blk,
    input  logic [63:0] tk,
    input  logic [7:0]  rc,
    input  logic        decrypt,
    input  logic        last,
    output logic [63:0] result
);

    logic [63:0] rk_s;
    logic [63:0] pre_s;
    logic [63:0] mix_s;

    // Forward: MC, AddConstant, AddTweakey, then PN and S-box unless last.
    // Inverse undoes those steps in reverse order; every layer is an involution.
    always_comb begin
        rk_s   = tk ^ rc_mask(rc);
        pre_s  = 64'h0;
        mix_s  = 64'h0;
        result = 64'h0;
        if (decrypt) begin
            if (last) begin
                pre_s = blk;
            end else begin
                pre_s = pn_inv_layer(sbox_layer(blk));
            end
            result = mc_layer(pre_s ^ rk_s);
        end else begin
            mix_s = mc_layer(blk) ^ rk_s;
            if (last) begin
                result = mix_s;
            end else begin
                result = sbox_layer(pn_layer(mix_s));
            end
        end
    end

endmodule

// File: rtl/craft_cipher_core.sv
// Iterative CRAFT encrypt/decrypt core with UNROLL rounds per clock.
// Ports: clk, rst (sync, active-high); request side in_valid/in_ready with
//        in_decrypt, in_block, in_tweak, in_key (K0 = [127:64], K1 = [63:0]);
//        result side out_valid/out_ready with out_block.
// One request at a time: IDLE accepts, RUN iterates, DONE holds the result.
module craft_cipher_core
    import craft_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [63:0]  in_block,
    input  logic [63:0]  in_tweak,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block
);

    localparam int CW = $clog2(ROUNDS) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] STEP     = CW'(UNROLL);
    localparam logic [CW-1:0] END_CNT  = CW'(ROUNDS);
    localparam bit UNROLL_OK = (UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4);
    localparam bit PARAMS_OK = UNROLL_OK && (ROUNDS >= 2) && (ROUNDS <= MAX_ROUNDS) &&
                               ((ROUNDS % (UNROLL_OK ? UNROLL : 1)) == 0);

    if (!PARAMS_OK) begin : g_bad_params
        $error("craft_cipher_core: ROUNDS must be 2..32 and divisible by UNROLL in {1,2,4}");
    end

    craft_state_t  state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n_s;
    logic [63:0]   blk_r, tweak_r;
    logic [127:0]  key_r;
    logic          decrypt_r;
    logic          in_ready_r, out_valid_r;
    logic [63:0]   out_block_r;
    logic          accept_s, step_s, finish_s;
    logic [63:0]   tk_s [4];
    logic [63:0]   chain_s [UNROLL+1];

    assign tk_s[0] = key_r[127:64] ^ tweak_r;
    assign tk_s[1] = key_r[63:0]   ^ tweak_r;
    assign tk_s[2] = key_r[127:64] ^ q_perm(tweak_r);
    assign tk_s[3] = key_r[63:0]   ^ q_perm(tweak_r);

    assign chain_s[0] = blk_r;

    // Round u of this clock handles index cnt+u (encrypt) or ROUNDS-1-(cnt+u) (decrypt).
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [CW-1:0] pos_s;
        logic [CW-1:0] idx_s;
        logic [4:0]    rc_sel_s;
        assign pos_s    = cnt_r + CW'(u);
        assign idx_s    = decrypt_r ? (LAST_IDX - pos_s) : pos_s;
        assign rc_sel_s = 5'(idx_s);
        craft_round_unit u_round (
            .blk     (chain_s[u]),
            .tk      (tk_s[idx_s[1:0]]),
            .rc      (RC_TABLE[rc_sel_s]),
            .decrypt (decrypt_r),
            .last    (idx_s == LAST_IDX),
            .result  (chain_s[u+1])
        );
    end

    // Next-state and datapath-control decode.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        cnt_n_s  = cnt_r + STEP;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_n  = ST_RUN;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_n_s == END_CNT) begin
                    finish_s = 1'b1;
                    state_n  = ST_DONE;
                end else begin
                    state_n  = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    // Request latch, round state iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            blk_r       <= 64'h0;
            tweak_r     <= 64'h0;
            key_r       <= 128'h0;
            decrypt_r   <= 1'b0;
            out_block_r <= 64'h0;
        end else begin
            if (accept_s) begin
                cnt_r     <= '0;
                blk_r     <= in_block;
                tweak_r   <= in_tweak;
                key_r     <= in_key;
                decrypt_r <= in_decrypt;
            end else if (step_s) begin
                cnt_r <= cnt_n_s;
                blk_r <= chain_s[UNROLL];
            end
            if (finish_s) begin
                out_block_r <= chain_s[UNROLL];
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;

endmodule

// File: tb/tb_craft_cipher_core.sv
// Bench for craft_cipher_core: five instances (ROUNDS/UNROLL = 32/1, 32/2,
// 32/4, 2/1, 31/1) share one stimulus stream. Encrypt expectations come from
// a nibble-array CRAFT model with LFSR-generated constants; decrypt
// expectations are the plaintexts that the model encrypted.
module tb_craft_cipher_core;

    localparam int ND = 5;
    localparam int RND [ND] = '{32, 32, 32, 2, 31};
    localparam int LAT [ND] = '{32, 16, 8, 2, 31};
    localparam logic [63:0]  P1 = 64'h0123456789abcdef;
    localparam logic [63:0]  T1 = 64'hfedcba9876543210;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;

    localparam int M_SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    localparam int M_P  [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int M_Q  [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    typedef struct {
        bit              dec;
        logic [63:0]     blk;
        logic [63:0]     tw;
        logic [127:0]    key;
        logic [4:0]      mask;
        logic [4:0][63:0] exp;
    } vec_t;

    logic clk, rst, in_valid, in_decrypt, out_ready;
    logic [63:0]  in_block, in_tweak;
    logic [127:0] in_key;
    logic [4:0]   rdy, vld;
    logic [63:0]  ob [ND];

    int pass_cnt = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    craft_cipher_core #(.ROUNDS(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_tweak(in_tweak), .in_key(in_key),
        .out_valid(vld[0]), .out_ready(out_ready), .out_block(ob[0]));
    craft_cipher_core #(.ROUNDS(32), .UNROLL(2)) dut_u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_tweak(in_tweak), .in_key(in_key),
        .out_valid(vld[1]), .out_ready(out_ready), .out_block(ob[1]));
    craft_cipher_core #(.ROUNDS(32), .UNROLL(4)) dut_u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_tweak(in_tweak), .in_key(in_key),
        .out_valid(vld[2]), .out_ready(out_ready), .out_block(ob[2]));
    craft_cipher_core #(.ROUNDS(2), .UNROLL(1)) dut_r2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_tweak(in_tweak), .in_key(in_key),
        .out_valid(vld[3]), .out_ready(out_ready), .out_block(ob[3]));
    craft_cipher_core #(.ROUNDS(31), .UNROLL(1)) dut_r31 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_tweak(in_tweak), .in_key(in_key),
        .out_valid(vld[4]), .out_ready(out_ready), .out_block(ob[4]));

    function automatic logic [63:0] model_enc(input logic [63:0] p, input logic [63:0] t,
                                              input logic [127:0] k, input int rounds);
        logic [3:0] s [16];
        logic [3:0] tmp [16];
        logic [3:0] tn [16];
        logic [3:0] qt [16];
        logic [3:0] tkn [4][16];
        logic [3:0] a;
        logic [2:0] b;
        logic [63:0] c;
        for (int i = 0; i < 16; i++) begin
            s[i]  = p[63-4*i -: 4];
            tn[i] = t[63-4*i -: 4];
        end
        for (int i = 0; i < 16; i++) qt[i] = tn[M_Q[i]];
        for (int i = 0; i < 16; i++) begin
            tkn[0][i] = k[127-4*i -: 4] ^ tn[i];
            tkn[1][i] = k[63-4*i -: 4]  ^ tn[i];
            tkn[2][i] = k[127-4*i -: 4] ^ qt[i];
            tkn[3][i] = k[63-4*i -: 4]  ^ qt[i];
        end
        a = 4'h1;
        b = 3'h1;
        for (int r = 0; r < rounds; r++) begin
            for (int j = 0; j < 4; j++) begin
                s[j]   = s[j] ^ s[8+j] ^ s[12+j];
                s[4+j] = s[4+j] ^ s[12+j];
            end
            s[4] = s[4] ^ a;
            s[5] = s[5] ^ {1'b0, b};
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ tkn[r % 4][i];
            if (r != rounds - 1) begin
                for (int i = 0; i < 16; i++) tmp[M_P[i]] = s[i];
                for (int i = 0; i < 16; i++) s[i] = 4'(M_SB[tmp[i]]);
            end
            a = {a[0] ^ a[1], a[3:1]};
            b = {b[0] ^ b[1], b[2:1]};
        end
        c = 64'h0;
        for (int i = 0; i < 16; i++) c[63-4*i -: 4] = s[i];
        return c;
    endfunction

    function automatic vec_t mk_enc(input logic [63:0] p, input logic [63:0] t, input logic [127:0] k);
        vec_t v;
        v.dec = 1'b0; v.blk = p; v.tw = t; v.key = k; v.mask = 5'b11111;
        for (int d = 0; d < ND; d++) v.exp[d] = model_enc(p, t, k, RND[d]);
        return v;
    endfunction

    function automatic vec_t mk_dec(input logic [63:0] c, input logic [63:0] t, input logic [127:0] k,
                                    input logic [63:0] p, input logic [4:0] mask);
        vec_t v;
        v.dec = 1'b1; v.blk = c; v.tw = t; v.key = k; v.mask = mask;
        for (int d = 0; d < ND; d++) v.exp[d] = p;
        return v;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic scramble_inputs();
        in_block   = rand64();
        in_tweak   = rand64();
        in_key     = {rand64(), rand64()};
        in_decrypt = 1'($urandom);
    endtask

    // Waits up to 40 cycles for every instance to raise out_valid; records latency and result.
    task automatic collect(output int lat [ND], output logic [63:0] res [ND]);
        bit done;
        for (int d = 0; d < ND; d++) begin
            lat[d] = 0;
            res[d] = 64'h0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            scramble_inputs();
            done = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (vld[d] && lat[d] == 0) begin
                    lat[d] = cyc;
                    res[d] = ob[d];
                end
                if (lat[d] == 0) done = 1'b0;
            end
            if (done) break;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int lat [ND];
        logic [63:0] res [ND];
        in_decrypt = v.dec; in_block = v.blk; in_tweak = v.tw; in_key = v.key;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(lat, res);
        for (int d = 0; d < ND; d++) begin
            if (v.mask[d]) begin
                check64($sformatf("%s block d%0d", tag, d), res[d], v.exp[d]);
                check64($sformatf("%s latency d%0d", tag, d), 64'(lat[d]), 64'(LAT[d]));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        int lat [ND];
        logic [63:0] res [ND];
        logic [63:0] c, p, t;
        logic [127:0] k;
        bit saw_valid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_decrypt = 1'b0; in_block = 64'h0; in_tweak = 64'h0; in_key = 128'h0;

        vecs[0] = mk_enc(64'h0, 64'h0, 128'h0);
        vecs[1] = mk_enc(P1, T1, K1);
        vecs[2] = mk_dec(model_enc(P1, T1, K1, 32), T1, K1, P1, 5'b00111);
        vecs[3] = mk_enc(64'hffffffffffffffff, 64'h0, 128'hffffffffffffffffffffffffffffffff);
        vecs[4] = mk_dec(model_enc(P1, T1, K1, 2), T1, K1, P1, 5'b01000);
        vecs[5] = mk_dec(model_enc(P1, T1, K1, 31), T1, K1, P1, 5'b10000);
        vecs[6] = mk_enc(64'h8000000000000001, 64'h0f0f0f0f0f0f0f0f,
                         128'h0123456789abcdeffedcba9876543210);

        repeat (3) @(posedge clk);
        #1;
        check64("reset in_ready", 64'(rdy), 64'h1f);
        check64("reset out_valid", 64'(vld), 64'h0);
        check64("reset out_block", ob[0], 64'h0);
        rst = 1'b0;

        for (int n = 0; n < 7; n++) apply_vec(vecs[n], $sformatf("vec%0d", n));

        for (int n = 0; n < 200; n++) begin
            p = rand64(); t = rand64(); k = {rand64(), rand64()};
            if (n % 2 == 0) apply_vec(mk_enc(p, t, k), $sformatf("rnd%0d", n));
            else apply_vec(mk_dec(model_enc(p, t, k, 32), t, k, p, 5'b00111), $sformatf("rnd%0d", n));
        end

        // Result held in DONE while out_ready stays low and inputs churn.
        in_decrypt = 1'b0; in_block = P1; in_tweak = T1; in_key = K1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(lat, res);
        check64("hold first result", res[0], vecs[1].exp[0]);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'(i % 2 == 0);
            @(posedge clk); #1;
            scramble_inputs();
            check64($sformatf("hold block c%0d", i), ob[0], vecs[1].exp[0]);
            check64($sformatf("hold valid c%0d", i), 64'(vld[0]), 64'h1);
            check64($sformatf("hold in_ready c%0d", i), 64'(rdy[0]), 64'h0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check64("handshake no same-cycle accept", 64'(rdy[0]), 64'h1);
        check64("handshake valid drop", 64'(vld[0]), 64'h0);
        @(posedge clk); #1;
        check64("idle stays idle", 64'(rdy[0]), 64'h1);

        // Reset in the middle of RUN with in_valid held high.
        in_decrypt = 1'b0; in_block = P1; in_tweak = T1; in_key = K1; in_valid = 1'b1;
        saw_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vld[0]) saw_valid = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (vld[0]) saw_valid = 1'b1;
        check64("midrun reset in_ready", 64'(rdy), 64'h1f);
        check64("midrun reset out_valid", 64'(vld), 64'h0);
        check64("midrun reset block d0", ob[0], 64'h0);
        check64("midrun reset block d2", ob[2], 64'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (vld[0]) saw_valid = 1'b1;
        end
        check64("discarded op never valid", 64'(saw_valid), 64'h0);
        apply_vec(vecs[1], "post-reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
